// File: rtl/alu_seq_divider.sv
// Multi-cycle restoring divider for the ALU: one quotient bit per clock,
// signed or unsigned operands, with div-by-zero and signed overflow flags.
module alu_seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_sel,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero,
    output logic             ov
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [3:0] LAST = 4'(WIDTH - 1);

    state_t state, state_nx;
    logic accept;
    logic [3:0] count;
    logic [WIDTH-1:0] dq;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic q_neg, r_neg, ov_case;

    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH:0] shifted, diff;
    logic div_is_zero;

    assign div_is_zero = (divisor == '0);
    assign dvd_mag = (signed_sel && dividend[WIDTH-1]) ? -dividend : dividend;
    assign dvs_mag = (signed_sel && divisor[WIDTH-1]) ? -divisor : divisor;
    assign shifted = {rem, dq[WIDTH-1]};
    assign diff = shifted - {1'b0, dvs};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            state <= state_nx;
            busy <= (state_nx == S_RUN) || (state_nx == S_FIX);
            done <= (state_nx == S_DONE);
        end
    end

    always_comb begin
        state_nx = state;
        accept = 1'b0;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    accept = 1'b1;
                    state_nx = div_is_zero ? S_DONE : S_RUN;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_RUN: begin
                if (count == LAST) begin
                    state_nx = S_FIX;
                end
            end
            S_FIX: state_nx = S_DONE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            dq <= '0;
            dvs <= '0;
            rem <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            ov_case <= 1'b0;
            quotient <= '0;
            remainder <= '0;
            div_zero <= 1'b0;
            ov <= 1'b0;
        end else if (accept) begin
            div_zero <= div_is_zero;
            ov <= 1'b0;
            count <= '0;
            rem <= '0;
            dq <= dvd_mag;
            dvs <= dvs_mag;
            q_neg <= signed_sel & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg <= signed_sel & dividend[WIDTH-1];
            ov_case <= signed_sel && (dividend == MIN_NEG) && (divisor == '1);
            if (div_is_zero) begin
                quotient <= '1;
                remainder <= dividend;
            end
        end else if (state == S_RUN) begin
            // A set sign bit means the trial went negative: restore.
            if (!diff[WIDTH]) begin
                rem <= diff[WIDTH-1:0];
                dq <= {dq[WIDTH-2:0], 1'b1};
            end else begin
                rem <= shifted[WIDTH-1:0];
                dq <= {dq[WIDTH-2:0], 1'b0};
            end
            count <= count + 4'd1;
        end else if (state == S_FIX) begin
            quotient <= q_neg ? -dq : dq;
            remainder <= r_neg ? -rem : rem;
            ov <= ov_case;
        end
    end

endmodule

// File: tb/tb_alu_seq_divider.sv
// Self-checking bench for alu_seq_divider: directed cases from the
// datasheet plus randomized operands against an arithmetic model.
module tb_alu_seq_divider;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic signed_sel = 1'b0;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic busy, done, div_zero, ov;
    logic [15:0] quotient, remainder;

    int checks = 0;
    int errors = 0;
    logic [15:0] prev_q = '0;
    logic [15:0] prev_r = '0;

    alu_seq_divider #(.WIDTH(16)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .signed_sel(signed_sel),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_zero(div_zero),
        .ov(ov)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic sel, input logic [15:0] a,
                                  input logic [15:0] b,
                                  output logic [15:0] q, output logic [15:0] r,
                                  output logic dz, output logic ovf);
        int sa, sb;
        dz = 1'b0;
        ovf = 1'b0;
        if (b == 16'h0) begin
            q = 16'hFFFF;
            r = a;
            dz = 1'b1;
        end else if (sel) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            if (sa == -32768 && sb == -1) begin
                q = 16'h8000;
                r = 16'h0000;
                ovf = 1'b1;
            end else begin
                q = 16'(sa / sb);
                r = 16'(sa % sb);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Called mid-cycle; start is sampled at the next rising edge (edge 0).
    // A second start with operands ia/ib is pulsed in cycle inj (if >= 0).
    // Returns at mid-cycle of the done cycle.
    task automatic run_op(input string tag, input logic sel,
                          input logic [15:0] a, input logic [15:0] b,
                          input int inj, input logic [15:0] ia,
                          input logic [15:0] ib);
        logic [15:0] eq, er;
        logic edz, eov;
        model(sel, a, b, eq, er, edz, eov);
        signed_sel = sel;
        dividend = a;
        divisor = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dividend = 16'($urandom);
        divisor = 16'($urandom);
        signed_sel = ~sel;
        if (!edz) begin
            for (int k = 0; k <= 16; k++) begin
                @(negedge clk);
                chk({tag, ":busy"}, {31'd0, busy}, 32'd1);
                chk({tag, ":nodone"}, {31'd0, done}, 32'd0);
                if (k == 0) begin
                    chk({tag, ":q_hold"}, {16'd0, quotient}, {16'd0, prev_q});
                    chk({tag, ":r_hold"}, {16'd0, remainder}, {16'd0, prev_r});
                    chk({tag, ":flags_clr"}, {30'd0, div_zero, ov}, 32'd0);
                end
                if (k == inj) begin
                    signed_sel = 1'b0;
                    dividend = ia;
                    divisor = ib;
                    start = 1'b1;
                    @(posedge clk);
                    #1;
                    start = 1'b0;
                end
            end
        end
        @(negedge clk);
        chk({tag, ":done"}, {31'd0, done}, 32'd1);
        chk({tag, ":busy_off"}, {31'd0, busy}, 32'd0);
        chk({tag, ":q"}, {16'd0, quotient}, {16'd0, eq});
        chk({tag, ":r"}, {16'd0, remainder}, {16'd0, er});
        chk({tag, ":dz"}, {31'd0, div_zero}, {31'd0, edz});
        chk({tag, ":ov"}, {31'd0, ov}, {31'd0, eov});
        prev_q = eq;
        prev_r = er;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("idle:done", {31'd0, done}, 32'd0);
            chk("idle:busy", {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        logic sel;
        logic [15:0] a, b;
        int pick;

        #2;
        chk("rst:outs", {busy, done, div_zero, ov, quotient[11:0], remainder},
            32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(2);

        run_op("u100_7", 1'b0, 16'd100, 16'd7, -1, 16'd0, 16'd0);
        idle_cycles(1);
        run_op("s-7_2", 1'b1, 16'hFFF9, 16'h0002, -1, 16'd0, 16'd0);
        run_op("u-7_2", 1'b0, 16'hFFF9, 16'h0002, -1, 16'd0, 16'd0);
        run_op("s_ovf", 1'b1, 16'h8000, 16'hFFFF, -1, 16'd0, 16'd0);
        run_op("u_8000", 1'b0, 16'h8000, 16'hFFFF, -1, 16'd0, 16'd0);
        idle_cycles(1);

        run_op("dz", 1'b0, 16'h1234, 16'h0000, -1, 16'd0, 16'd0);
        idle_cycles(3);
        chk("dz:q_held", {16'd0, quotient}, 32'h0000FFFF);
        chk("dz:flag_held", {31'd0, div_zero}, 32'd1);

        run_op("ign_1000_3", 1'b0, 16'd1000, 16'd3, 5, 16'd50, 16'd5);
        run_op("b2b_50_5", 1'b0, 16'd50, 16'd5, -1, 16'd0, 16'd0);
        idle_cycles(1);

        // Reset in the middle of a division.
        signed_sel = 1'b0;
        dividend = 16'hFFFF;
        divisor = 16'h0003;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 8; k++) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst:outs", {busy, done, div_zero, ov, quotient[11:0],
            remainder}, 32'd0);
        chk("mid_rst:q_hi", {28'd0, quotient[15:12]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        prev_q = '0;
        prev_r = '0;
        idle_cycles(3);
        run_op("post_rst_9_4", 1'b0, 16'd9, 16'd4, -1, 16'd0, 16'd0);

        for (int n = 0; n < 40; n++) begin
            sel = 1'($urandom);
            a = 16'($urandom);
            b = 16'($urandom);
            pick = int'($urandom_range(0, 9));
            if (pick == 0) b = 16'h0000;
            else if (pick == 1) b = 16'($urandom_range(1, 15));
            else if (pick == 2) b = 16'hFFFF;
            else if (pick == 3) begin
                a = 16'h8000;
                b = 16'hFFFF;
            end
            run_op("rand", sel, a, b, -1, 16'd0, 16'd0);
            if ($urandom_range(0, 1) == 1) idle_cycles(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
